// File: rtl/nco_multi.sv
// Multi-channel NCO: per-channel phase accumulators with sine/square/saw/mute
// waveforms and a full-precision mixed sum. Three-stage pipeline: accumulate, waveform, output.
module nco_multi #(
    parameter  int NUM_CH     = 4,
    parameter  int PHASE_W    = 24,
    parameter  int LUT_ADDR_W = 8,
    parameter  int SAMPLE_W   = 14,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W      = SAMPLE_W + $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         next_sample,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [PHASE_W-1:0]           cfg_fcw,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_phase_rst,
    output logic [NUM_CH*SAMPLE_W-1:0]   ch_samples,
    output logic signed [MIX_W-1:0]      mix,
    output logic                         sample_valid
);

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_MUTE   = 2'd3
    } mode_e;

    localparam int  LUT_DEPTH = 2 ** LUT_ADDR_W;
    localparam int  AMP       = 2 ** (SAMPLE_W - 1) - 1;
    localparam real PI        = 3.14159265358979323846;

    localparam logic signed [SAMPLE_W-1:0] FULL_POS = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] FULL_NEG = SAMPLE_W'(-AMP);

    // Sine table is built at elaboration time; rounding is half-away-from-zero.
    function automatic logic [LUT_DEPTH*SAMPLE_W-1:0] gen_sine_lut();
        logic [LUT_DEPTH*SAMPLE_W-1:0] t;
        real x;
        int  v;
        t = '0;
        for (int k = 0; k < LUT_DEPTH; k++) begin
            x = real'(AMP) * $sin(2.0 * PI * real'(k) / real'(LUT_DEPTH));
            v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
            t[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(v);
        end
        return t;
    endfunction

    localparam logic [LUT_DEPTH*SAMPLE_W-1:0] SINE_LUT = gen_sine_lut();

    logic [PHASE_W-1:0]         r_phase   [NUM_CH];
    logic [PHASE_W-1:0]         r_fcw     [NUM_CH];
    mode_e                      r_mode    [NUM_CH];
    logic                       r_valid_s0;
    logic                       r_valid_s1;
    logic signed [SAMPLE_W-1:0] r_wave_s1 [NUM_CH];

    logic                       w_ch_in_range;
    logic [NUM_CH-1:0]          w_cfg_hit;
    logic [LUT_ADDR_W-1:0]      w_addr    [NUM_CH];
    logic signed [SAMPLE_W-1:0] w_wave    [NUM_CH];
    logic signed [MIX_W-1:0]    w_mix;
    logic [NUM_CH*SAMPLE_W-1:0] w_pack;

    // Out-of-range channel numbers are possible whenever NUM_CH is not a power of two.
    always_comb begin
        w_ch_in_range = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            w_cfg_hit[i] = cfg_we && w_ch_in_range && (cfg_ch == CH_W'(i));
        end
    end

    // Stage 0: accumulators and per-channel configuration.
    always_ff @(posedge clk) begin
        // NOTE: per-channel state is a few flops, not a RAM, so it is safe to reset every entry.
        if (!rst_n) begin
            r_valid_s0 <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_phase[i] <= '0;
                r_fcw[i]   <= '0;
                r_mode[i]  <= MODE_SINE;
            end
        end else begin
            // NOTE: non-blocking, so the advance below sees the pre-edge FCW even when rewritten this edge.
            r_valid_s0 <= next_sample;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_hit[i] && cfg_phase_rst) begin
                    r_phase[i] <= '0;
                end else if (next_sample) begin
                    r_phase[i] <= r_phase[i] + r_fcw[i];
                end
                if (w_cfg_hit[i]) begin
                    r_fcw[i]  <= cfg_fcw;
                    r_mode[i] <= mode_e'(cfg_mode);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        for (int i = 0; i < NUM_CH; i++) begin
            w_addr[i] = r_phase[i][PHASE_W-1 -: LUT_ADDR_W];
            w_wave[i] = '0;
            case (r_mode[i])
                MODE_SINE:   w_wave[i] = SINE_LUT[int'(w_addr[i])*SAMPLE_W +: SAMPLE_W];
                MODE_SQUARE: w_wave[i] = r_phase[i][PHASE_W-1] ? FULL_NEG : FULL_POS;
                MODE_SAW:    w_wave[i] = {~r_phase[i][PHASE_W-1],
                                          r_phase[i][PHASE_W-2 -: SAMPLE_W-1]};
                default:     w_wave[i] = '0;
            endcase
        end
    end

    // Stage 1: registered table read / waveform select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_s1 <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_wave_s1[i] <= '0;
            end
        end else begin
            r_valid_s1 <= r_valid_s0;
            if (r_valid_s0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_wave_s1[i] <= w_wave[i];
                end
            end
        end
    end

    // Sign-extended sum; MIX_W carries enough guard bits that it cannot overflow.
    always_comb begin
        w_mix  = '0;
        w_pack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_mix = w_mix + MIX_W'(r_wave_s1[i]);
            w_pack[i*SAMPLE_W +: SAMPLE_W] = r_wave_s1[i];
        end
    end

    // Stage 2: outputs hold between updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            ch_samples   <= '0;
            mix          <= '0;
        end else begin
            sample_valid <= r_valid_s1;
            if (r_valid_s1) begin
                ch_samples <= w_pack;
                mix        <= w_mix;
            end
        end
    end

endmodule

// File: tb/tb_nco_multi.sv
// Directed self-checking bench for nco_multi; a second 5-channel instance covers out-of-range channel writes.
module tb_nco_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        next_sample;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_fcw;
    logic [1:0]  cfg_mode;
    logic        cfg_phase_rst;
    logic [55:0] ch_samples;
    logic signed [15:0] mix;
    logic        sample_valid;

    logic        n5_next;
    logic        n5_we;
    logic [2:0]  n5_ch;
    logic [23:0] n5_fcw;
    logic [1:0]  n5_mode;
    logic        n5_prst;
    logic [69:0] n5_samples;
    logic signed [16:0] n5_mix;
    logic        n5_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nco_multi u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_sample   (next_sample),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_fcw       (cfg_fcw),
        .cfg_mode      (cfg_mode),
        .cfg_phase_rst (cfg_phase_rst),
        .ch_samples    (ch_samples),
        .mix           (mix),
        .sample_valid  (sample_valid)
    );

    nco_multi #(.NUM_CH(5)) u_dut5 (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_sample   (n5_next),
        .cfg_we        (n5_we),
        .cfg_ch        (n5_ch),
        .cfg_fcw       (n5_fcw),
        .cfg_mode      (n5_mode),
        .cfg_phase_rst (n5_prst),
        .ch_samples    (n5_samples),
        .mix           (n5_mix),
        .sample_valid  (n5_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic integer chv(input logic [55:0] s, input int i);
        logic signed [13:0] t;
        t = s[i*14 +: 14];
        return t;
    endfunction

    function automatic integer chv5(input logic [69:0] s, input int i);
        logic signed [13:0] t;
        t = s[i*14 +: 14];
        return t;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; next_sample = 1'b0; cfg_we = 1'b0; cfg_phase_rst = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input logic [23:0] fcw, input logic [1:0] mode, input logic prst);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_fcw = fcw; cfg_mode = mode; cfg_phase_rst = prst;
        tick();
        cfg_we = 1'b0; cfg_phase_rst = 1'b0;
    endtask

    // Waits (bounded) for the pulse belonging to a request issued at the last edge.
    task automatic collect(output int lat, output logic [55:0] smp, output logic signed [15:0] mx);
        lat = -1; smp = 'x; mx = 'x;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (sample_valid === 1'b1) begin
                lat = c; smp = ch_samples; mx = mix;
                break;
            end
        end
    endtask

    task automatic do_request(output int lat, output logic [55:0] smp, output logic signed [15:0] mx);
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        collect(lat, smp, mx);
    endtask

    task automatic test_reset();
        int lat; logic [55:0] smp; logic signed [15:0] mx; integer mv;
        rst_n = 1'b0; next_sample = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_fcw = '0;
        cfg_mode = '0; cfg_phase_rst = 1'b0;
        tick();
        tick();
        total++; if (ch_samples !== 56'd0) begin bad++; $display("FAIL reset_samples: got %h want 0", ch_samples); end
        total++; if (mix !== 16'sd0) begin bad++; $display("FAIL reset_mix: got %0d want 0", mix); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        rst_n = 1'b1;
        for (int r = 0; r < 5; r++) begin
            do_request(lat, smp, mx);
            mv = mx;
            total++; if (lat !== 2) begin bad++; $display("FAIL zero_fcw_latency[%0d]: got %0d want 2", r, lat); end
            total++; if (smp !== 56'd0) begin bad++; $display("FAIL zero_fcw_samples[%0d]: got %h want 0", r, smp); end
            total++; if (mv !== 0) begin bad++; $display("FAIL zero_fcw_mix[%0d]: got %0d want 0", r, mv); end
        end
    endtask

    task automatic test_sine();
        int lat; logic [55:0] smp; logic signed [15:0] mx;
        int issued; int got; integer s64; integer s128; integer s192; integer m64;
        apply_reset();
        cfg_write(0, 24'h010000, 2'd0, 1'b0);
        do_request(lat, smp, mx);
        total++; if (lat !== 2) begin bad++; $display("FAIL sine_latency1: got %0d want 2", lat); end
        total++; if (chv(smp, 0) !== 201) begin bad++; $display("FAIL sine_req1: got %0d want 201", chv(smp, 0)); end
        do_request(lat, smp, mx);
        total++; if (lat !== 2) begin bad++; $display("FAIL sine_latency2: got %0d want 2", lat); end
        total++; if (chv(smp, 0) !== 402) begin bad++; $display("FAIL sine_req2: got %0d want 402", chv(smp, 0)); end
        issued = 2; got = 2; s64 = 'x; s128 = 'x; s192 = 'x; m64 = 'x;
        for (int c = 0; c < 400 && got < 192; c++) begin
            next_sample = (issued < 192);
            tick();
            if (next_sample) issued++;
            if (sample_valid === 1'b1) begin
                got++;
                if (got == 64)  begin s64 = chv(ch_samples, 0); m64 = mix; end
                if (got == 128) s128 = chv(ch_samples, 0);
                if (got == 192) s192 = chv(ch_samples, 0);
            end
        end
        next_sample = 1'b0;
        total++; if (got !== 192) begin bad++; $display("FAIL sine_pulse_count: got %0d want 192", got); end
        total++; if (s64 !== 8191) begin bad++; $display("FAIL sine_req64: got %0d want 8191", s64); end
        total++; if (m64 !== 8191) begin bad++; $display("FAIL sine_mix64: got %0d want 8191", m64); end
        total++; if (s128 !== 0) begin bad++; $display("FAIL sine_req128: got %0d want 0", s128); end
        total++; if (s192 !== -8191) begin bad++; $display("FAIL sine_req192: got %0d want -8191", s192); end
    endtask

    task automatic test_square_saw();
        int lat; logic [55:0] smp; logic signed [15:0] mx; integer mv;
        int e_sq[4]  = '{-8191, 8191, -8191, 8191};
        int e_saw[4] = '{-4096, 0, 4096, -8192};
        int e_mix[4] = '{-12287, 8191, -4095, -1};
        apply_reset();
        cfg_write(1, 24'h800000, 2'd1, 1'b0);
        cfg_write(2, 24'h400000, 2'd2, 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_request(lat, smp, mx);
            mv = mx;
            total++; if (chv(smp, 1) !== e_sq[r]) begin bad++; $display("FAIL square[%0d]: got %0d want %0d", r, chv(smp, 1), e_sq[r]); end
            total++; if (chv(smp, 2) !== e_saw[r]) begin bad++; $display("FAIL saw[%0d]: got %0d want %0d", r, chv(smp, 2), e_saw[r]); end
            total++; if (mv !== e_mix[r]) begin bad++; $display("FAIL sq_saw_mix[%0d]: got %0d want %0d", r, mv, e_mix[r]); end
        end
    endtask

    task automatic test_mix();
        int lat; logic [55:0] smp; logic signed [15:0] mx; integer mv;
        apply_reset();
        for (int c = 0; c < 4; c++) cfg_write(c, 24'h400000, 2'd0, 1'b1);
        do_request(lat, smp, mx);
        mv = mx;
        for (int c = 0; c < 4; c++) begin
            total++; if (chv(smp, c) !== 8191) begin bad++; $display("FAIL mix_ch[%0d]: got %0d want 8191", c, chv(smp, c)); end
        end
        total++; if (mv !== 32764) begin bad++; $display("FAIL mix_full: got %0d want 32764", mv); end
        cfg_write(3, 24'h400000, 2'd3, 1'b0);
        do_request(lat, smp, mx);
        mv = mx;
        total++; if (chv(smp, 3) !== 0) begin bad++; $display("FAIL mix_muted_ch3: got %0d want 0", chv(smp, 3)); end
        total++; if (mv !== 0) begin bad++; $display("FAIL mix_after_mute: got %0d want 0", mv); end
    endtask

    task automatic test_simultaneous();
        int lat; logic [55:0] smp; logic signed [15:0] mx; integer mv;
        apply_reset();
        for (int c = 0; c < 4; c++) cfg_write(c, 24'h200000, 2'd0, 1'b0);
        do_request(lat, smp, mx);
        mv = mx;
        total++; if (mv !== 23168) begin bad++; $display("FAIL simul_base_mix: got %0d want 23168", mv); end
        // Phase reset on ch0 in the same cycle as a request.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_fcw = 24'h200000; cfg_mode = 2'd0; cfg_phase_rst = 1'b1;
        next_sample = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_phase_rst = 1'b0; next_sample = 1'b0;
        collect(lat, smp, mx);
        mv = mx;
        total++; if (chv(smp, 0) !== 0) begin bad++; $display("FAIL simul_prst_ch0: got %0d want 0", chv(smp, 0)); end
        total++; if (chv(smp, 1) !== 8191) begin bad++; $display("FAIL simul_prst_ch1: got %0d want 8191", chv(smp, 1)); end
        total++; if (mv !== 24573) begin bad++; $display("FAIL simul_prst_mix: got %0d want 24573", mv); end
        do_request(lat, smp, mx);
        total++; if (chv(smp, 0) !== 5792) begin bad++; $display("FAIL simul_after_prst_ch0: got %0d want 5792", chv(smp, 0)); end
        // FCW rewrite on ch1 in the same cycle as a request: old FCW applies first.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_fcw = 24'h400000; cfg_mode = 2'd0;
        next_sample = 1'b1;
        tick();
        cfg_we = 1'b0; next_sample = 1'b0;
        collect(lat, smp, mx);
        total++; if (chv(smp, 1) !== 0) begin bad++; $display("FAIL simul_fcw_old: got %0d want 0", chv(smp, 1)); end
        total++; if (chv(smp, 0) !== 8191) begin bad++; $display("FAIL simul_fcw_ch0: got %0d want 8191", chv(smp, 0)); end
        do_request(lat, smp, mx);
        mv = mx;
        total++; if (chv(smp, 1) !== -8191) begin bad++; $display("FAIL simul_fcw_new: got %0d want -8191", chv(smp, 1)); end
        total++; if (mv !== -13983) begin bad++; $display("FAIL simul_fcw_mix: got %0d want -13983", mv); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [69:0] smp; integer mv;
        n5_we = 1'b1; n5_mode = 2'd0; n5_prst = 1'b1; n5_fcw = 24'h400000;
        for (int c = 0; c < 5; c++) begin
            n5_ch = 3'(c);
            tick();
        end
        n5_fcw = 24'h800000; n5_mode = 2'd3; n5_prst = 1'b1;
        n5_ch = 3'd7; tick();
        n5_ch = 3'd5; tick();
        n5_we = 1'b0; n5_prst = 1'b0;
        n5_next = 1'b1;
        tick();
        n5_next = 1'b0;
        lat = -1; smp = 'x; mv = 'x;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (n5_valid === 1'b1) begin lat = c; smp = n5_samples; mv = n5_mix; break; end
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL oor_latency: got %0d want 2", lat); end
        for (int c = 0; c < 5; c++) begin
            total++; if (chv5(smp, c) !== 8191) begin bad++; $display("FAIL oor_ch[%0d]: got %0d want 8191", c, chv5(smp, c)); end
        end
        total++; if (mv !== 40955) begin bad++; $display("FAIL oor_mix: got %0d want 40955", mv); end
    endtask

    task automatic test_wrap_burst();
        int issued; int got; int extra;
        apply_reset();
        cfg_write(0, 24'hFFFFFF, 2'd0, 1'b0);
        cfg_write(1, 24'hFFFFFF, 2'd2, 1'b0);
        issued = 0; got = 0;
        for (int c = 0; c < 400 && got < 300; c++) begin
            next_sample = (issued < 300);
            tick();
            if (next_sample) issued++;
            if (sample_valid === 1'b1) begin
                got++;
                total++; if (chv(ch_samples, 0) !== -201) begin bad++; $display("FAIL wrap_sine[%0d]: got %0d want -201", got, chv(ch_samples, 0)); end
                total++; if (chv(ch_samples, 1) !== 8191) begin bad++; $display("FAIL wrap_saw[%0d]: got %0d want 8191", got, chv(ch_samples, 1)); end
            end
        end
        next_sample = 1'b0;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (sample_valid !== 1'b0) extra++;
        end
        total++; if (got !== 300) begin bad++; $display("FAIL wrap_pulse_count: got %0d want 300", got); end
        total++; if (extra !== 0) begin bad++; $display("FAIL wrap_extra_pulses: got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid_burst();
        int seen; int late;
        seen = 0;
        next_sample = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (sample_valid === 1'b1) seen++;
        end
        total++; if (seen !== 2) begin bad++; $display("FAIL midrst_pre_pulses: got %0d want 2", seen); end
        rst_n = 1'b0;
        tick();
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", sample_valid); end
        total++; if (ch_samples !== 56'd0) begin bad++; $display("FAIL midrst_samples: got %h want 0", ch_samples); end
        total++; if (mix !== 16'sd0) begin bad++; $display("FAIL midrst_mix: got %0d want 0", mix); end
        tick();
        rst_n = 1'b1;
        next_sample = 1'b0;
        late = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (sample_valid !== 1'b0) late++;
        end
        total++; if (late !== 0) begin bad++; $display("FAIL midrst_late_pulses: got %0d want 0", late); end
        total++; if (ch_samples !== 56'd0) begin bad++; $display("FAIL midrst_hold_samples: got %h want 0", ch_samples); end
    endtask

    initial begin
        n5_next = 1'b0; n5_we = 1'b0; n5_ch = '0; n5_fcw = '0; n5_mode = '0; n5_prst = 1'b0;
        test_reset();
        test_sine();
        test_square_saw();
        test_mix();
        test_simultaneous();
        test_out_of_range();
        test_wrap_burst();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
